// File: rtl/icache_fetch_responder.sv
// ---------------------------------------------------------------------------
// icache_fetch_responder
//
// Direct-mapped, read-only instruction cache between the PC/IF logic and
// instruction memory. A hit returns the instruction word in the same cycle.
// A miss raises busywait, fetches a 128-bit block from memory, installs it,
// and the fetch then completes when the hit is re-evaluated.
//
// Ports:
//   clk           system clock, all state updates on posedge
//   reset         synchronous active-high reset
//   read          fetch request from the IF stage
//   address       byte address of the instruction (bits [1:0] ignored)
//   readdata      fetched instruction word (0 when not a hit)
//   busywait      stall for PC and IF/ID while the word is unavailable
//   mem_read      block read request to instruction memory
//   mem_address   block address of the outstanding miss (address[31:4])
//   mem_readdata  128-bit block from memory, word 0 in bits [31:0]
//   mem_busywait  memory busy; block valid when low while mem_read is high
// ---------------------------------------------------------------------------
module icache_fetch_responder #(
   parameter int INDEX_BITS = 3,
   parameter int TAG_BITS   = 25
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         read,
   input  logic [31:0]  address,
   output logic [31:0]  readdata,
   output logic         busywait,
   output logic         mem_read,
   output logic [27:0]  mem_address,
   input  logic [127:0] mem_readdata,
   input  logic         mem_busywait
);

   localparam int LINES = 1 << INDEX_BITS;

   // The tag must cover exactly the address bits above index and offset.
   if (TAG_BITS != 32 - 4 - INDEX_BITS) begin : g_tag_bits_check
      $error("icache_fetch_responder: TAG_BITS must equal 28 - INDEX_BITS");
   end

   typedef enum logic [1:0] {
      IDLE,
      MEM_READ,
      UPDATE
   } state_t;

   state_t state;
   state_t next_state;

   logic [LINES-1:0]    valid;
   logic [TAG_BITS-1:0] tag_array  [LINES];
   logic [127:0]        data_array [LINES];
   logic [127:0]        fill_buffer;

   logic [1:0]            offset;
   logic [INDEX_BITS-1:0] index;
   logic [TAG_BITS-1:0]   tag;
   logic                  hit;
   logic                  start_fill;
   logic                  capture_fill;

   logic [INDEX_BITS-1:0] fill_index;
   logic [TAG_BITS-1:0]   fill_tag;

   // Byte-within-word bits are never used by an instruction fetch.
   logic unused_addr_bits;
   assign unused_addr_bits = ^address[1:0];

   assign offset = address[3:2];
   assign index  = address[3+INDEX_BITS:4];
   assign tag    = address[31:4+INDEX_BITS];

   // The latched block address already carries the index and tag of the
   // line being filled, so no separate latch is kept for them.
   assign fill_index = mem_address[INDEX_BITS-1:0];
   assign fill_tag   = mem_address[27:INDEX_BITS];

   // Hit detection and the same-cycle word return. Both outputs are forced
   // quiet while reset is high so the pipeline never sees a stale hit.
   always_comb begin
      hit      = read & valid[index] & (tag_array[index] == tag);
      readdata = 32'd0;
      busywait = 1'b0;
      if (!reset) begin
         busywait = read & ~hit;
         if (hit) begin
            readdata = data_array[index][{offset, 5'b00000} +: 32];
         end
      end
   end

   // Next-state logic for the miss handler. A new miss can only start from
   // IDLE; UPDATE always returns to IDLE so the hit is re-evaluated against
   // the freshly installed line before any further miss is considered.
   always_comb begin
      next_state   = state;
      start_fill   = 1'b0;
      capture_fill = 1'b0;
      case (state)
         IDLE: begin
            if (read && !hit) begin
               next_state = MEM_READ;
               start_fill = 1'b1;
            end
         end
         MEM_READ: begin
            if (!mem_busywait) begin
               next_state   = UPDATE;
               capture_fill = 1'b1;
            end
         end
         UPDATE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // State register; reset abandons any fill in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Memory request: raised on the edge that leaves IDLE with a miss and
   // dropped on the edge that captures the block, so it is only ever high
   // in MEM_READ and never spans two requests.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_read    <= 1'b0;
         mem_address <= 28'd0;
      end else if (start_fill) begin
         mem_read    <= 1'b1;
         mem_address <= address[31:4];
      end else if (capture_fill) begin
         mem_read    <= 1'b0;
      end
   end

   // Holds the returned block for the single UPDATE cycle.
   always_ff @(posedge clk) begin
      if (capture_fill && !reset) begin
         fill_buffer <= mem_readdata;
      end
   end

   // Valid bits are the only cache state cleared by reset; tags and data
   // are meaningless until their valid bit is set again.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid <= '0;
      end else if (state == UPDATE) begin
         valid[fill_index] <= 1'b1;
      end
   end

   // Install the block and tag of the completed fill, overwriting whatever
   // the line held before.
   always_ff @(posedge clk) begin
      if (!reset && state == UPDATE) begin
         data_array[fill_index] <= fill_buffer;
         tag_array[fill_index]  <= fill_tag;
      end
   end

endmodule

// File: tb/tb_icache_fetch_responder.sv
// ---------------------------------------------------------------------------
// tb_icache_fetch_responder
//
// Drives directed and random fetch traffic into icache_fetch_responder,
// plays the role of instruction memory, and checks every cycle against a
// transaction-level reference: a table of which blocks are resident, one
// outstanding fill at a time, and a memory image computed from the block
// address. Any resident word must read back as the memory image.
// ---------------------------------------------------------------------------
module tb_icache_fetch_responder;

   logic         clk = 1'b0;
   logic         reset;
   logic         read;
   logic [31:0]  address;
   logic [31:0]  readdata;
   logic         busywait;
   logic         mem_read;
   logic [27:0]  mem_address;
   logic [127:0] mem_readdata;
   logic         mem_busywait;

   int compared   = 0;
   int mismatched = 0;

   // Reference model state
   bit          m_valid [8];
   logic [24:0] m_tag   [8];
   bit          m_fill;
   logic [27:0] m_fill_blk;
   bit          m_install;
   logic [27:0] m_install_blk;
   int          wait_left;
   int          fixed_latency;

   icache_fetch_responder #(.INDEX_BITS(3), .TAG_BITS(25)) dut (
      .clk          (clk),
      .reset        (reset),
      .read         (read),
      .address      (address),
      .readdata     (readdata),
      .busywait     (busywait),
      .mem_read     (mem_read),
      .mem_address  (mem_address),
      .mem_readdata (mem_readdata),
      .mem_busywait (mem_busywait)
   );

   always #5 clk = ~clk;

   // Instruction memory image: block 4 carries the known program fragment,
   // every other block a pattern unique to its block and word number.
   function automatic logic [127:0] memBlock(input logic [27:0] blk);
      logic [127:0] b;
      if (blk == 28'h0000004) begin
         b = 128'h0000_0013_0040_0093_00A0_0113_0000_0000;
      end else begin
         for (int w = 0; w < 4; w++) begin
            b[w*32 +: 32] = {2'b10, 2'(w), blk} ^ 32'h1234_5678;
         end
      end
      return b;
   endfunction

   function automatic logic [31:0] memWord(input logic [31:0] addr);
      logic [127:0] b;
      b = memBlock(addr[31:4]);
      return b[addr[3:2]*32 +: 32];
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s at %0t: got %h, expected %h", tag, $time, observed, expected);
      end
   endtask

   task automatic resetModel();
      for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
      m_fill    = 1'b0;
      m_install = 1'b0;
   endtask

   // One clock cycle: drive inputs and the memory side, check outputs at the
   // falling edge, then advance the reference model across the rising edge.
   task automatic applyStimulus(input bit r, input bit rd, input logic [31:0] addr);
      bit resident;
      bit exp_hit;
      reset   = r;
      read    = rd;
      address = addr;
      if (m_fill && wait_left == 0) begin
         mem_busywait = 1'b0;
         mem_readdata = memBlock(m_fill_blk);
      end else begin
         if (m_fill) begin
            mem_busywait = 1'b1;
            wait_left--;
         end else begin
            mem_busywait = 1'($urandom_range(0, 1));
         end
         mem_readdata = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      resident = m_valid[addr[6:4]] && (m_tag[addr[6:4]] == addr[31:7]);
      exp_hit  = !r && rd && resident;

      @(negedge clk);
      checkOutput("busywait", {31'd0, busywait}, {31'd0, (!r && rd && !exp_hit)});
      checkOutput("readdata", readdata, exp_hit ? memWord(addr) : 32'd0);
      checkOutput("mem_read", {31'd0, mem_read}, {31'd0, m_fill});
      if (m_fill) begin
         checkOutput("mem_address", {4'd0, mem_address}, {4'd0, m_fill_blk});
      end

      if (r) begin
         resetModel();
      end else if (m_install) begin
         m_valid[m_install_blk[2:0]] = 1'b1;
         m_tag[m_install_blk[2:0]]   = m_install_blk[27:3];
         m_install = 1'b0;
      end else if (m_fill) begin
         if (!mem_busywait) begin
            m_fill        = 1'b0;
            m_install     = 1'b1;
            m_install_blk = m_fill_blk;
         end
      end else if (rd && !resident) begin
         m_fill     = 1'b1;
         m_fill_blk = addr[31:4];
         wait_left  = (fixed_latency > 0) ? fixed_latency : int'($urandom_range(0, 4));
      end

      @(posedge clk);
      #1;
   endtask

   task automatic holdAddress(input bit rd, input logic [31:0] addr, input int n);
      for (int k = 0; k < n; k++) applyStimulus(1'b0, rd, addr);
   endtask

   initial begin
      logic [31:0] addr;
      bit          rd;
      bit          rst;
      int          n;

      reset         = 1'b1;
      read          = 1'b0;
      address       = 32'd0;
      mem_busywait  = 1'b1;
      mem_readdata  = '0;
      fixed_latency = 3;
      wait_left     = 0;
      m_fill_blk    = '0;
      m_install_blk = '0;
      for (int i = 0; i < 8; i++) m_tag[i] = '0;
      resetModel();
      repeat (2) @(posedge clk);
      #1;

      $display("[TB] reset state");
      applyStimulus(1'b1, 1'b0, 32'd0);

      $display("[TB] cold miss on 0x40");
      holdAddress(1'b1, 32'h0000_0040, 9);

      $display("[TB] hits within the same block");
      applyStimulus(1'b0, 1'b1, 32'h0000_0044);
      applyStimulus(1'b0, 1'b1, 32'h0000_0048);
      applyStimulus(1'b0, 1'b1, 32'h0000_004C);

      $display("[TB] conflict miss on line 4");
      holdAddress(1'b1, 32'h0000_00C0, 9);
      holdAddress(1'b1, 32'h0000_0040, 9);

      $display("[TB] reset during a fill");
      fixed_latency = 5;
      holdAddress(1'b1, 32'h0000_0100, 2);
      applyStimulus(1'b1, 1'b1, 32'h0000_0100);
      holdAddress(1'b0, 32'h0000_0100, 6);
      holdAddress(1'b1, 32'h0000_0100, 10);

      $display("[TB] read deasserted");
      fixed_latency = 2;
      holdAddress(1'b0, 32'h0000_0500, 3);
      holdAddress(1'b1, 32'h0000_0500, 8);

      $display("[TB] address change during a fill");
      fixed_latency = 3;
      holdAddress(1'b1, 32'h0000_0200, 2);
      holdAddress(1'b1, 32'h0000_0300, 14);
      holdAddress(1'b1, 32'h0000_0200, 2);

      $display("[TB] random traffic");
      fixed_latency = 0;
      for (int i = 0; i < 80; i++) begin
         addr = (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 7)) << 4)
              | 32'($urandom_range(0, 15));
         if ($urandom_range(0, 7) == 0) addr = addr ^ 32'hFFF0_0000;
         rd  = ($urandom_range(0, 9) != 0);
         rst = ($urandom_range(0, 29) == 0);
         n   = int'($urandom_range(1, 8));
         for (int j = 0; j < n; j++) applyStimulus((j == 0) ? rst : 1'b0, rd, addr);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
